fd_pipe_reg: RTL and testbench
==============================

// Module: fd_pipe_reg
// PURPOSE
//  Fetch->Decode pipeline register; sits directly downstream of the PC stage and IM.
//  Latches F_PC/F_instr each cycle and applies stall, flush and interrupt (req) redirection.
//  Tags fetch exceptions (AdEL on bad PC) and carries the branch-delay-slot flag to D for CP0/EPC.
// PARAMETERS
//  PC_RESET     32'h0000_3000  D_PC value after reset
//  EXC_ENTRY    32'h0000_4180  D_PC loaded alongside the bubble when req is asserted
//  IM_LO        32'h0000_3000  lowest legal fetch address (inclusive)
//  IM_HI        32'h0000_6ffc  highest legal fetch address (inclusive)
//  EXC_ADEL     5'd4           ExcCode for an instruction-fetch address error
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  req        in   1   exception/interrupt taken this cycle (from CP0); highest priority after reset
//  stall      in   1   hazard-unit stall; hold every D_* output
//  flush      in   1   kill the F-stage instruction (e.g. eret in D); insert bubble
//  D_jump     in   1   instruction currently in D is a branch/jump (marks F instr as delay slot)
//  F_PC       in   32  PC of the instruction being fetched (from PC stage)
//  F_instr    in   32  IM output for F_PC
//  D_PC       out  32  PC of the instruction in D
//  D_instr    out  32  instruction in D (32'h0 = nop/bubble)
//  D_ExcCode  out  5   pending exception code; 5'd0 = none
//  D_BD       out  1   D instruction sits in a delay slot
//  D_valid    out  1   1 = real instruction, 0 = bubble
// BEHAVIOUR
//  - Reset (async, immediate): D_PC=PC_RESET, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
//  - Per rising edge, priority req > stall > flush > load:
//    req:   D_PC=EXC_ENTRY, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0 (req overrides stall).
//    stall: all D_* registers hold.
//    flush: D_PC=F_PC, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
//    load:  D_PC=F_PC, D_BD=D_jump, D_valid=1; fetch check below.
//  - Fetch check (load only): adel = (F_PC[1:0]!=2'b00) | (F_PC<IM_LO) | (F_PC>IM_HI), unsigned 32-bit compare.
//    adel=1: D_instr=0 (never forward IM garbage), D_ExcCode=EXC_ADEL. adel=0: D_instr=F_instr, D_ExcCode=0.
//  - D_BD sampled from D_jump in the same cycle as load; stall preserves it (EPC correction stays valid).
//  - Latency: exactly 1 cycle F->D; no combinational path from any input to any output.
//  - Boundaries: F_PC=IM_HI legal; IM_HI+4 and IM_LO-4 raise AdEL; misaligned and out-of-range together -> single AdEL.
//  - stall&flush together: stall wins (flush is re-presented by control next cycle).
//  - Reset asserted mid-stall or mid-req: reset values immediately; first edge after deassertion is a normal load.
// STRUCTURE
//  - Shared constants header: EXC_ADEL and the other ExcCode values, PC_RESET, EXC_ENTRY, IM_LO/IM_HI.
//  - One natural sub-module: fetch_addr_check (combinational adel from F_PC); everything else is one always block.
// TESTING
//  1 reset pulse between edges -> outputs go to PC_RESET/0/0/0/0 without waiting for clk.
//  2 F_PC=32'h3004, F_instr=32'h2408_0001, no ctrl -> next edge D_PC=3004, D_instr=24080001, D_valid=1, ExcCode=0.
//  3 stall=1 for 3 cycles while F_PC advances -> D_* frozen; stall=0 -> loads current F_PC.
//  4 F_PC=32'h3002, then 32'h7000 -> D_instr=0, D_ExcCode=4, D_valid=1; F_PC=32'h6ffc -> ExcCode=0.
//  5 req=1 together with stall=1 -> D_PC=32'h4180, D_instr=0, D_valid=0; flush=1 -> bubble carrying F_PC.
//  6 D_jump=1 on load of 32'h3008 -> D_BD=1; then stall 2 cycles -> D_BD stays 1; next load with D_jump=0 -> D_BD=0.

Source files
------------

// File: rtl/fd_pipe_reg_pkg.sv
// Shared constants and types for the Fetch->Decode pipeline register.
// Holds the memory map limits, reset/exception vectors and the ExcCode values
// used throughout the core, plus the D-stage register record.
package fd_pipe_reg_pkg;

    // Address map and vectors
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6ffc;

    // Canonical no-op word used for bubbles and killed fetches
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    // ExcCode values as seen by CP0 Cause.ExcCode
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // What the register does on a given edge, in priority order
    typedef enum logic [1:0] {
        UPD_REQ   = 2'd0,
        UPD_HOLD  = 2'd1,
        UPD_FLUSH = 2'd2,
        UPD_LOAD  = 2'd3
    } upd_e;

    // Everything the D stage receives from F
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc_code;
        logic        bd;
        logic        valid;
    } d_reg_t;

    // A bubble carrying a given PC (used for reset, req and flush)
    function automatic d_reg_t make_bubble(input logic [31:0] pc);
        d_reg_t b;
        b.pc       = pc;
        b.instr    = INSTR_NOP;
        b.exc_code = EXC_NONE;
        b.bd       = 1'b0;
        b.valid    = 1'b0;
        return b;
    endfunction

    // Priority resolution: req > stall > flush > load
    function automatic upd_e pick_update(input logic req,
                                         input logic stall,
                                         input logic flush);
        upd_e u;
        if (req)        u = UPD_REQ;
        else if (stall) u = UPD_HOLD;
        else if (flush) u = UPD_FLUSH;
        else            u = UPD_LOAD;
        return u;
    endfunction

endpackage

// File: rtl/fd_pipe_reg_if.sv
// F->D boundary bundle: control from hazard unit / CP0, fetch data, D outputs.
// The master side (control + fetch stage) drives req/stall/flush/D_jump/F_*;
// the slave side (the pipeline register) drives the D_* outputs.
interface fd_pipe_reg_if;

    // Control
    logic        req;
    logic        stall;
    logic        flush;
    logic        D_jump;

    // Fetch stage
    logic [31:0] F_PC;
    logic [31:0] F_instr;

    // Decode stage
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;
    logic        D_valid;

    modport master (
        output req, stall, flush, D_jump, F_PC, F_instr,
        input  D_PC, D_instr, D_ExcCode, D_BD, D_valid
    );

    modport slave (
        input  req, stall, flush, D_jump, F_PC, F_instr,
        output D_PC, D_instr, D_ExcCode, D_BD, D_valid
    );

endinterface

// File: rtl/fd_pipe_reg_fetch_addr_check.sv
// Instruction-fetch address check: flags misaligned or out-of-map PCs (AdEL).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed only on a load.
module fd_pipe_reg_fetch_addr_check
    import fd_pipe_reg_pkg::*;
#(
    parameter logic [31:0] LO = IM_LO,
    parameter logic [31:0] HI = IM_HI
) (
    input  logic [31:0] F_PC,
    output logic        adel
);

    logic misaligned;
    logic below_lo;
    logic above_hi;

    // Any one violation raises a single AdEL; unsigned compares against the map
    always_comb begin
        misaligned = (F_PC[1:0] != 2'b00);
        below_lo   = (F_PC < LO);
        above_hi   = (F_PC > HI);
        adel       = misaligned | below_lo | above_hi;
    end

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch->Decode pipeline register with stall/flush/req redirection and AdEL tagging.
// Latency: exactly one cycle F->D; all outputs come straight from flops.
// Backpressure: stall holds every D output; req overrides stall; stall beats flush.
module fd_pipe_reg
    import fd_pipe_reg_pkg::*;
#(
    parameter logic [31:0] P_PC_RESET  = PC_RESET,
    parameter logic [31:0] P_EXC_ENTRY = EXC_ENTRY,
    parameter logic [31:0] P_IM_LO     = IM_LO,
    parameter logic [31:0] P_IM_HI     = IM_HI
) (
    input  logic           clk,
    input  logic           reset,
    fd_pipe_reg_if.slave   bus
);

    d_reg_t d_reg_d;
    d_reg_t d_reg_q;
    upd_e   upd;
    logic   adel;

    fd_pipe_reg_fetch_addr_check #(
        .LO (P_IM_LO),
        .HI (P_IM_HI)
    ) u_fetch_addr_check (
        .F_PC (bus.F_PC),
        .adel (adel)
    );

    // Next D-stage contents: resolve priority, then build the record
    always_comb begin
        d_reg_d = d_reg_q;
        upd     = pick_update(bus.req, bus.stall, bus.flush);
        case (upd)
            UPD_REQ:   d_reg_d = make_bubble(P_EXC_ENTRY);
            UPD_HOLD:  d_reg_d = d_reg_q;
            UPD_FLUSH: d_reg_d = make_bubble(bus.F_PC);
            UPD_LOAD: begin
                d_reg_d.pc    = bus.F_PC;
                d_reg_d.bd    = bus.D_jump;
                d_reg_d.valid = 1'b1;
                // A bad fetch address never forwards whatever IM returned
                if (adel) begin
                    d_reg_d.instr    = INSTR_NOP;
                    d_reg_d.exc_code = EXC_ADEL;
                end else begin
                    d_reg_d.instr    = bus.F_instr;
                    d_reg_d.exc_code = EXC_NONE;
                end
            end
            default:   d_reg_d = d_reg_q;
        endcase
    end

    // D-stage register; reset lands on the boot vector as a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_reg_q <= make_bubble(P_PC_RESET);
        end else begin
            d_reg_q <= d_reg_d;
        end
    end

    // Outputs are direct flop taps
    always_comb begin
        bus.D_PC      = d_reg_q.pc;
        bus.D_instr   = d_reg_q.instr;
        bus.D_ExcCode = d_reg_q.exc_code;
        bus.D_BD      = d_reg_q.bd;
        bus.D_valid   = d_reg_q.valid;
    end

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed bench for fd_pipe_reg: reset, load, stall, AdEL boundaries, req/flush, delay slot.
module tb_fd_pipe_reg;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    fd_pipe_reg_if bus ();

    fd_pipe_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the full D record against hand-computed values
    task automatic chk_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] exc, input logic bd, input logic valid);
        chk({tag, ".pc"},    bus.D_PC,               pc);
        chk({tag, ".instr"}, bus.D_instr,            instr);
        chk({tag, ".exc"},   32'(bus.D_ExcCode),     32'(exc));
        chk({tag, ".bd"},    32'(bus.D_BD),          32'(bd));
        chk({tag, ".valid"}, 32'(bus.D_valid),       32'(valid));
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic rq, input logic st, input logic fl, input logic jp);
        bus.F_PC    = pc;
        bus.F_instr = instr;
        bus.req     = rq;
        bus.stall   = st;
        bus.flush   = fl;
        bus.D_jump  = jp;
    endtask

    // One clock edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        reset = 1'b0;
        chk_d("rst", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);

        // Plain load
        drive(32'h3004, 32'h2408_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("load", 32'h3004, 32'h2408_0001, 5'd0, 1'b0, 1'b1);

        // Async reset between edges takes effect without a clock
        reset = 1'b1;
        #2;
        chk_d("async_rst", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(32'h3004, 32'h2408_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("reload.pc", bus.D_PC, 32'h3004);

        // Stall for three cycles while F advances
        drive(32'h3008, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("stall1.pc", bus.D_PC, 32'h3004);
        drive(32'h300c, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h3010, 32'h3333_3333, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_d("stall3", 32'h3004, 32'h2408_0001, 5'd0, 1'b0, 1'b1);
        drive(32'h3010, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("unstall", 32'h3010, 32'h3333_3333, 5'd0, 1'b0, 1'b1);

        // Fetch address errors and boundaries
        drive(32'h3002, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("adel_mis", 32'h3002, 32'h0, 5'd4, 1'b0, 1'b1);
        drive(32'h7000, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("adel_hi4", 32'h7000, 32'h0, 5'd4, 1'b0, 1'b1);
        drive(32'h6ffc, 32'h8c09_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("im_hi", 32'h6ffc, 32'h8c09_0000, 5'd0, 1'b0, 1'b1);
        drive(32'h2ffc, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("adel_lo4", 32'h2ffc, 32'h0, 5'd4, 1'b0, 1'b1);
        drive(32'h7001, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("adel_both.exc", 32'(bus.D_ExcCode), 32'd4);
        drive(32'h3000, 32'h0000_0abc, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("im_lo", 32'h3000, 32'h0000_0abc, 5'd0, 1'b0, 1'b1);

        // req overrides stall
        drive(32'h3014, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_d("req_stall", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
        // flush inserts a bubble carrying F_PC
        drive(32'h3020, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_d("flush", 32'h3020, 32'h0, 5'd0, 1'b0, 1'b0);
        // stall beats flush
        drive(32'h3024, 32'h0bad_f00d, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h3028, 32'h5555_5555, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_d("stall_flush", 32'h3024, 32'h0bad_f00d, 5'd0, 1'b0, 1'b1);

        // Delay-slot flag
        drive(32'h3008, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_d("bd_set", 32'h3008, 32'h0000_0001, 5'd0, 1'b1, 1'b1);
        drive(32'h300c, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("bd_stall.bd", 32'(bus.D_BD), 32'd1);
        chk("bd_stall.pc", bus.D_PC, 32'h3008);
        drive(32'h300c, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("bd_clr", 32'h300c, 32'h0000_0002, 5'd0, 1'b0, 1'b1);
        // req clears a pending delay-slot flag
        drive(32'h3010, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("bd_pre_req.bd", 32'(bus.D_BD), 32'd1);
        drive(32'h3014, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("req_bd", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);

        // Reset mid-stall, then first edge is a normal load
        drive(32'h3030, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h3034, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        #2;
        chk_d("rst_stall", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(32'h3040, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_d("post_rst", 32'h3040, 32'h0000_0007, 5'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
